core_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous global data memory between all cores. It sits between the cores' load/store units and the memory macro, beside the task scheduler. Each cycle it grants at most one core's read or write to the memory port. It returns read data with a per-core acknowledge after a fixed two-cycle latency.

---
 rtl/core_mem_arbiter_if.sv | 44 ++++
 rtl/core_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_core_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// Core load/store request bus and single-port memory bus shared through core_mem_arbiter.
// MEM_ARB_VGA_EN adds the read-only VGA requester signals.
interface core_mem_arbiter_if #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8
) ();
  logic [NUM_CORES-1:0]        Req;
  logic [NUM_CORES-1:0]        Wr_En;
  logic [NUM_CORES*ADDR_W-1:0] Addr;
  logic [NUM_CORES*DATA_W-1:0] Wr_Data;
  logic [NUM_CORES-1:0]        Ack;
  logic [DATA_W-1:0]           Rd_Data;
  logic                        mem_en;
  logic                        mem_wr_en;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wr_data;
  logic [DATA_W-1:0]           mem_rd_data;
`ifdef MEM_ARB_VGA_EN
  logic                        vga_req;
  logic [ADDR_W-1:0]           vga_addr;
  logic                        vga_ack;
`endif

  // Arbiter side
  modport slave (
    input  Req, Wr_En, Addr, Wr_Data, mem_rd_data,
`ifdef MEM_ARB_VGA_EN
    input  vga_req, vga_addr,
    output vga_ack,
`endif
    output Ack, Rd_Data, mem_en, mem_wr_en, mem_addr, mem_wr_data
  );

  // Cores plus memory macro side
  modport master (
    output Req, Wr_En, Addr, Wr_Data, mem_rd_data,
`ifdef MEM_ARB_VGA_EN
    output vga_req, vga_addr,
    input  vga_ack,
`endif
    input  Ack, Rd_Data, mem_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter granting one core access per cycle to a single-port memory,
// acknowledging two cycles after the grant. MEM_ARB_VGA_EN adds a top-priority VGA reader.
module core_mem_arbiter #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  core_mem_arbiter_if.slave  bus
);
  localparam int unsigned ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic [ID_W-1:0]      s1_id_q, s1_id_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;

  logic                 s1_core_c;
  logic [NUM_CORES-1:0] elig_c;
  logic                 grant_c;
  logic [ID_W-1:0]      win_c;
  logic [ADDR_W-1:0]    addr_arr [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];
  logic                 wr_arr [NUM_CORES];

`ifdef MEM_ARB_VGA_EN
  logic s1_vga_q, s1_vga_d;
  logic vga_ack_q, vga_ack_d;
  logic vga_grant_c;

  assign s1_core_c   = mem_en_q & ~s1_vga_q;
  assign vga_grant_c = bus.vga_req & ~(mem_en_q & s1_vga_q);
  assign bus.vga_ack = vga_ack_q;
`else
  assign s1_core_c = mem_en_q;
`endif

  // A core already in stage 1 or being acknowledged is not eligible again
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign addr_arr[g]  = bus.Addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.Wr_Data[g*DATA_W +: DATA_W];
    assign wr_arr[g]    = bus.Wr_En[g];
    assign elig_c[g]    = bus.Req[g] & ~ack_q[g] & ~(s1_core_c & (s1_id_q == ID_W'(g)));
  end

  // First eligible core at or after rr_ptr, wrapping
  always_comb begin
    grant_c = 1'b0;
    win_c   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!grant_c && elig_c[ID_W'((32'(rr_ptr_q) + k) % NUM_CORES)]) begin
        grant_c = 1'b1;
        win_c   = ID_W'((32'(rr_ptr_q) + k) % NUM_CORES);
      end
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    mem_en_d      = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    s1_id_d       = s1_id_q;
    ack_d         = '0;
    if (s1_core_c) begin
      ack_d[s1_id_q] = 1'b1;
    end
    if (grant_c) begin
      mem_en_d      = 1'b1;
      mem_wr_en_d   = wr_arr[win_c];
      mem_addr_d    = addr_arr[win_c];
      mem_wr_data_d = wdata_arr[win_c];
      s1_id_d       = win_c;
      rr_ptr_d      = (win_c == ID_W'(NUM_CORES - 1)) ? '0 : win_c + ID_W'(1);
    end
`ifdef MEM_ARB_VGA_EN
    s1_vga_d  = s1_vga_q;
    vga_ack_d = mem_en_q & s1_vga_q;
    // VGA overrides any core winner and leaves the rotation untouched
    if (vga_grant_c) begin
      mem_en_d      = 1'b1;
      mem_wr_en_d   = 1'b0;
      mem_addr_d    = bus.vga_addr;
      mem_wr_data_d = mem_wr_data_q;
      s1_id_d       = s1_id_q;
      rr_ptr_d      = rr_ptr_q;
      s1_vga_d      = 1'b1;
    end else if (grant_c) begin
      s1_vga_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      s1_id_q       <= '0;
      ack_q         <= '0;
`ifdef MEM_ARB_VGA_EN
      s1_vga_q      <= 1'b0;
      vga_ack_q     <= 1'b0;
`endif
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mem_en_q      <= mem_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      s1_id_q       <= s1_id_d;
      ack_q         <= ack_d;
`ifdef MEM_ARB_VGA_EN
      s1_vga_q      <= s1_vga_d;
      vga_ack_q     <= vga_ack_d;
`endif
    end
  end

  assign bus.Ack         = ack_q;
  assign bus.Rd_Data     = bus.mem_rd_data;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios with literal expectations, then random
// core traffic against a time-window reference model of the arbiter and a shadow memory.
module tb_core_mem_arbiter;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MEM_ARB_VGA_EN
  initial begin
    bus.vga_req  = 1'b0;
    bus.vga_addr = '0;
  end
`endif

  // Memory macro: synchronous read, one-cycle latency
  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
      else               bus.mem_rd_data   <= mem[bus.mem_addr];
    end
  end

  // Stimulus for the current cycle
  bit            rst_v;
  bit            req_v  [N];
  bit            wr_v   [N];
  logic [AW-1:0] addr_v [N];
  logic [DW-1:0] wd_v   [N];

  // Reference model state
  int            cyc;
  int            rr_m;
  int            last_g [N];
  bit            gflag  [N];
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wd;
  bit            e_en   [8];
  bit            e_wr   [8];
  logic [AW-1:0] e_addr [8];
  logic [DW-1:0] e_wd   [8];
  logic [N-1:0]  e_ack  [8];
  bit            e_rdv  [8];
  logic [DW-1:0] e_rd   [8];

  // Random core agents
  bit rnd;
  int dens;
  bit c_pend  [N];
  int issue_c [N];
  int maxw;

  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    reset = rst_v;
    for (int i = 0; i < N; i++) begin
      bus.Req[i]              = req_v[i];
      bus.Wr_En[i]            = wr_v[i];
      bus.Addr[i*AW +: AW]    = addr_v[i];
      bus.Wr_Data[i*DW +: DW] = wd_v[i];
    end
  endtask

  // A core is busy for the grant cycle and the two cycles after it
  task automatic decide();
    int s1, s2, win, idx;
    s1 = (cyc + 1) % 8;
    s2 = (cyc + 2) % 8;
    if (rst_v) begin
      rr_m = 0; hold_addr = '0; hold_wd = '0;
      for (int i = 0; i < N; i++) begin
        last_g[i] = -100; gflag[i] = 1'b0; issue_c[i] = cyc + 1;
      end
      e_en[s1] = 1'b0; e_wr[s1] = 1'b0; e_addr[s1] = '0; e_wd[s1] = '0;
      e_ack[s1] = '0; e_rdv[s1] = 1'b0; e_ack[s2] = '0; e_rdv[s2] = 1'b0;
      return;
    end
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr_m + k) % N;
      if (win < 0 && req_v[idx] && (cyc - last_g[idx]) > 2) win = idx;
    end
    e_ack[s2] = '0;
    e_rdv[s2] = 1'b0;
    if (win < 0) begin
      e_en[s1] = 1'b0; e_wr[s1] = 1'b0; e_addr[s1] = hold_addr; e_wd[s1] = hold_wd;
    end else begin
      last_g[win] = cyc;
      gflag[win]  = 1'b1;
      rr_m        = (win + 1) % N;
      hold_addr   = addr_v[win];
      hold_wd     = wd_v[win];
      e_en[s1] = 1'b1; e_wr[s1] = wr_v[win]; e_addr[s1] = hold_addr; e_wd[s1] = hold_wd;
      e_ack[s2] = N'(1) << win;
      if (wr_v[win]) shadow[hold_addr] = hold_wd;
      else begin
        e_rdv[s2] = 1'b1;
        e_rd[s2]  = shadow[hold_addr];
      end
      if (rnd && (cyc - issue_c[win]) > maxw) maxw = cyc - issue_c[win];
    end
  endtask

  task automatic compare();
    int s;
    s = cyc % 8;
    chk("mem_en",      32'(bus.mem_en),      32'(e_en[s]));
    chk("mem_wr_en",   32'(bus.mem_wr_en),   32'(e_wr[s]));
    chk("mem_addr",    32'(bus.mem_addr),    32'(e_addr[s]));
    chk("mem_wr_data", 32'(bus.mem_wr_data), 32'(e_wd[s]));
    chk("ack",         32'(bus.Ack),         32'(e_ack[s]));
    if (e_rdv[s]) chk("rd_data", 32'(bus.Rd_Data), 32'(e_rd[s]));
  endtask

  task automatic tick();
    drive();
    decide();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
  endtask

  task automatic gen();
    rst_v = ($urandom_range(599) == 0);
    for (int i = 0; i < N; i++) begin
      if (c_pend[i] && gflag[i] && cyc >= last_g[i] + 3) c_pend[i] = 1'b0;
      if (!c_pend[i]) begin
        if (int'($urandom_range(99)) < dens) begin
          c_pend[i]  = 1'b1;
          gflag[i]   = 1'b0;
          issue_c[i] = cyc;
          req_v[i]   = 1'b1;
          wr_v[i]    = 1'($urandom_range(1));
          addr_v[i]  = AW'($urandom_range(15));
          wd_v[i]    = DW'($urandom);
        end else begin
          req_v[i] = 1'b0;
        end
      end
    end
  endtask

  int ack_cnt [N];

  initial begin
    total = 0; bad = 0; cyc = 0; rnd = 1'b0; maxw = 0; dens = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = DW'(i * 37 + 11);
      shadow[i] = DW'(i * 37 + 11);
    end
    mem[8'h2A] = 8'h5C; shadow[8'h2A] = 8'h5C;
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = AW'(8'h40 + i); wd_v[i] = '0;
      last_g[i] = -100; gflag[i] = 1'b0; c_pend[i] = 1'b0; issue_c[i] = 0; ack_cnt[i] = 0;
    end

    rst_v = 1'b1;
    tick(); tick();
    chk("reset_mem_en", 32'(bus.mem_en), 32'h0);
    chk("reset_ack",    32'(bus.Ack),    32'h0);
    rst_v = 1'b0;
    idle(1);

    // Single read by core 3
    req_v[3] = 1'b1; wr_v[3] = 1'b0; addr_v[3] = 8'h2A;
    tick();
    chk("t1_mem_en",   32'(bus.mem_en),   32'h1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h2A);
    tick();
    chk("t1_ack",      32'(bus.Ack),      32'h0008);
    chk("t1_rd_data",  32'(bus.Rd_Data),  32'h5C);
    idle(2);

    // Core 5 writes 0x77 to 0x10 then reads it back
    req_v[5] = 1'b1; wr_v[5] = 1'b1; addr_v[5] = 8'h10; wd_v[5] = 8'h77;
    tick();
    chk("t2_mem_wr_en",   32'(bus.mem_wr_en),   32'h1);
    chk("t2_mem_wr_data", 32'(bus.mem_wr_data), 32'h77);
    tick();
    chk("t2_wr_ack",      32'(bus.Ack),         32'h0020);
    wr_v[5] = 1'b0;
    tick(); tick(); tick();
    chk("t2_rd_ack",      32'(bus.Ack),         32'h0020);
    chk("t2_rd_data",     32'(bus.Rd_Data),     32'h77);
    idle(2);

    // Rotation: every core requesting continuously from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b1; wr_v[i] = 1'b0; addr_v[i] = AW'(8'h40 + i);
    end
    for (int k = 0; k <= 16; k++) begin
      tick();
      chk("t3_order", 32'(bus.mem_addr), 32'(8'h40 + (k % 16)));
      if (k >= 1) for (int i = 0; i < N; i++) ack_cnt[i] += int'(bus.Ack[i]);
    end
    for (int i = 0; i < N; i++) chk("t3_ack_once", 32'(ack_cnt[i]), 32'h1);
    idle(3);

    // Wrap: park rr_ptr at 14 then request 15, 1, 0
    req_v[13] = 1'b1;
    tick();
    idle(3);
    req_v[15] = 1'b1; req_v[0] = 1'b1; req_v[1] = 1'b1;
    tick(); chk("t4_first",  32'(bus.mem_addr), 32'h4F);
    tick(); chk("t4_second", 32'(bus.mem_addr), 32'h40);
    tick(); chk("t4_third",  32'(bus.mem_addr), 32'h41);
    idle(3);

    // No regrant while in flight
    req_v[2] = 1'b1;
    tick(); chk("t5_n1", 32'(bus.mem_en), 32'h1);
    tick(); chk("t5_n2", 32'(bus.mem_en), 32'h0);
    tick(); chk("t5_n3", 32'(bus.mem_en), 32'h0);
    tick(); chk("t5_n4", 32'(bus.mem_en), 32'h1);
    chk("t5_n4_addr", 32'(bus.mem_addr), 32'h42);
    idle(3);

    // Reset while core 1's read sits in stage 1
    req_v[1] = 1'b1;
    tick();
    chk("t6_granted", 32'(bus.mem_en), 32'h1);
    rst_v = 1'b1;
    tick();
    chk("t6_mem_en", 32'(bus.mem_en), 32'h0);
    chk("t6_ack",    32'(bus.Ack),    32'h0);
    rst_v = 1'b0;
    req_v[1] = 1'b1; req_v[2] = 1'b1;
    tick(); chk("t6_rr_zero", 32'(bus.mem_addr), 32'h41);
    tick(); chk("t6_next",    32'(bus.mem_addr), 32'h42);
    idle(3);

    // Random traffic
    rnd = 1'b1;
    for (int i = 0; i < N; i++) begin
      c_pend[i] = 1'b0; req_v[i] = 1'b0;
    end
    for (int t = 0; t < 4000; t++) begin
      if (t % 250 == 0) begin
        case ($urandom_range(2))
          0:       dens = 5;
          1:       dens = 35;
          default: dens = 90;
        endcase
      end
      gen();
      tick();
    end
    rst_v = 1'b0;
    idle(4);

    total++;
    if (maxw > 3 * N) begin
      bad++;
      $display("FAIL max_wait: got %0d cycles, allowed at most %0d", maxw, 3 * N);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
